pc_seq_unit: RTL and testbench

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

---
 rtl/pc_seq_unit.sv | 128 ++++++++++++
 tb/tb_pc_seq_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: sequential/branch/call/return/halt control,
// condition flags and a circular return-address stack.
module pc_seq_unit #(
  parameter int                ADDR_W    = 16,
  parameter int                IMM_W     = 12,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br,
  input  logic [2:0]        cond,
  input  logic              call,
  input  logic              ret,
  input  logic              hlt_in,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] ret_reg,
  input  logic              set_z,
  input  logic              set_vn,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_n,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              z_flag,
  output logic              v_flag,
  output logic              n_flag,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_pc;
  logic              r_z, r_v, r_n;
  logic              r_halted, r_ovf, r_unf;
  logic [PTR_W-1:0]  r_wp;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic [ADDR_W-1:0] w_link, w_target;
  logic [PTR_W-1:0]  w_top;
  logic              w_empty, w_full, w_taken, w_adv, w_push;

  assign w_link   = r_pc + ADDR_W'(1);
  assign w_target = w_link + ADDR_W'($signed(imm));
  assign w_top    = r_wp - PTR_W'(1);
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_adv    = !stall && !r_halted;
  assign w_push   = w_adv && !hlt_in && !ret && call;

  // Branch condition uses the flags registered before this edge.
  always_comb begin
    w_taken = 1'b0;
    case (cond)
      3'b000:  w_taken = !r_z;
      3'b001:  w_taken = r_z;
      3'b010:  w_taken = !r_z && !r_n;
      3'b011:  w_taken = r_n;
      3'b100:  w_taken = r_z || !r_n;
      3'b101:  w_taken = r_z || r_n;
      3'b110:  w_taken = r_v;
      default: w_taken = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
      r_n      <= 1'b0;
      r_halted <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_wp     <= '0;
      r_cnt    <= '0;
    end else if (w_adv) begin
      if (set_z) r_z <= alu_z;
      if (set_vn) begin
        r_v <= alu_v;
        r_n <= alu_n;
      end
      if (hlt_in) begin
        r_halted <= 1'b1;
      end else if (ret) begin
        if (w_empty) begin
          r_pc  <= ret_reg;
          r_unf <= 1'b1;
        end else begin
          r_pc  <= r_ras[w_top];
          r_wp  <= w_top;
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end else if (call) begin
        r_pc <= w_target;
        // When full, the write pointer sits on the oldest entry, so it is overwritten.
        r_wp <= r_wp + PTR_W'(1);
        if (w_full) r_ovf <= 1'b1;
        else        r_cnt <= r_cnt + CNT_W'(1);
      end else if (br && w_taken) begin
        r_pc <= w_target;
      end else begin
        r_pc <= w_link;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_wp] <= w_link;
  end

  assign pc        = r_pc;
  assign link_addr = w_link;
  assign z_flag    = r_z;
  assign v_flag    = r_v;
  assign n_flag    = r_n;
  assign halted    = r_halted;
  assign ras_empty = w_empty;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed self-checking bench for pc_seq_unit with default parameters.
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, br, call, ret, hlt_in;
  logic [2:0]  cond;
  logic [11:0] imm;
  logic [15:0] ret_reg;
  logic        set_z, set_vn, alu_z, alu_v, alu_n;
  logic [15:0] pc, link_addr;
  logic        z_flag, v_flag, n_flag, halted, ras_empty, ras_ovf, ras_unf;

  int total = 0;
  int bad   = 0;

  pc_seq_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br(br), .cond(cond),
    .call(call), .ret(ret), .hlt_in(hlt_in), .imm(imm), .ret_reg(ret_reg),
    .set_z(set_z), .set_vn(set_vn), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .pc(pc), .link_addr(link_addr), .z_flag(z_flag), .v_flag(v_flag),
    .n_flag(n_flag), .halted(halted), .ras_empty(ras_empty),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    stall = 0; br = 0; cond = 3'b000; call = 0; ret = 0; hlt_in = 0;
    imm = '0; ret_reg = '0; set_z = 0; set_vn = 0; alu_z = 0; alu_v = 0; alu_n = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 0;
    step();
    step();
    #2 rst_n = 1;
    step();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Brings the DUT out of reset with pc=0 and nothing executed yet.
  task automatic fresh();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    #2;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic chk_pc(input string name, input logic [15:0] exp);
    total++;
    if (pc !== exp) begin
      bad++;
      $display("FAIL %s: pc=%h expected %h", name, pc, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    total++;
    if ({pc, z_flag, v_flag, n_flag, halted, ras_empty, ras_ovf, ras_unf} !== {16'h0, 7'b0000100}) begin
      bad++;
      $display("FAIL reset_state: pc=%h z=%b v=%b n=%b h=%b e=%b o=%b u=%b",
               pc, z_flag, v_flag, n_flag, halted, ras_empty, ras_ovf, ras_unf);
    end
    @(negedge clk);
    rst_n = 1;
    chk_pc("seq0", 16'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_pc("seq", 16'(i));
    end
    total++;
    if ({z_flag, v_flag, n_flag, halted} !== 4'b0) begin
      bad++;
      $display("FAIL seq_flags: zvnh=%b expected 0000", {z_flag, v_flag, n_flag, halted});
    end
  endtask

  task automatic test_branch_flags();
    fresh();
    for (int i = 0; i < 10; i++) step();
    chk_pc("reach10", 16'd10);
    set_z = 1; alu_z = 1; br = 1; cond = 3'b001; imm = 12'd5;
    step();
    chk_pc("eq_old_flag", 16'd11);
    total++;
    if (z_flag !== 1'b1) begin bad++; $display("FAIL z_set: z=%b expected 1", z_flag); end
    set_z = 0;
    step();
    chk_pc("eq_taken", 16'd17);
    br = 0; set_vn = 1; alu_v = 1; alu_n = 1;
    step();
    chk_pc("vn_seq", 16'd18);
    set_vn = 0; br = 1; cond = 3'b011; imm = 12'd2;
    step();
    chk_pc("lt_taken", 16'd21);
    cond = 3'b010;
    step();
    chk_pc("gt_not_taken", 16'd22);
    cond = 3'b110; imm = 12'hFFF;
    step();
    chk_pc("ov_taken_neg", 16'd22);
    cond = 3'b000; imm = 12'd9;
    step();
    chk_pc("ne_not_taken", 16'd23);
    br = 0;
  endtask

  task automatic test_wrap();
    fresh();
    ret = 1; ret_reg = 16'hFFFF;
    step();
    chk_pc("ret_empty_load", 16'hFFFF);
    ret = 0;
    step();
    chk_pc("wrap_seq", 16'h0000);
    step();
    step();
    chk_pc("at2", 16'd2);
    br = 1; cond = 3'b111; imm = 12'hFFC;
    step();
    chk_pc("neg_wrap", 16'hFFFF);
    br = 0;
  endtask

  task automatic test_ras();
    logic [15:0] exp_ret [4];
    exp_ret[0] = 16'd17; exp_ret[1] = 16'd13; exp_ret[2] = 16'd9; exp_ret[3] = 16'd5;
    fresh();
    call = 1; imm = 12'd3;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        total++;
        if (ras_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early: ovf=%b expected 0", ras_ovf); end
      end
      step();
      chk_pc("call", 16'(4 * i));
    end
    total++;
    if (ras_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: ovf=%b expected 1", ras_ovf); end
    call = 0; ret = 1; ret_reg = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_pc("ret_lifo", exp_ret[i]);
    end
    total++;
    if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
      bad++; $display("FAIL drained: empty=%b unf=%b expected 1 0", ras_empty, ras_unf);
    end
    step();
    chk_pc("ret_unf1", 16'h0100);
    total++;
    if (ras_unf !== 1'b1) begin bad++; $display("FAIL unf_set: unf=%b expected 1", ras_unf); end
    ret_reg = 16'h0200;
    step();
    chk_pc("ret_unf2", 16'h0200);
    ret = 0;
  endtask

  task automatic test_priority();
    fresh();
    call = 1; br = 1; cond = 3'b111; imm = 12'd3;
    step();
    chk_pc("call_over_br", 16'd4);
    total++;
    if (ras_empty !== 1'b0) begin bad++; $display("FAIL call_pushed: empty=%b expected 0", ras_empty); end
    ret = 1;
    step();
    chk_pc("ret_over_call", 16'd1);
    total++;
    if (ras_empty !== 1'b1) begin bad++; $display("FAIL ret_popped: empty=%b expected 1", ras_empty); end
    ret = 0; call = 0; br = 0;
  endtask

  task automatic test_stall();
    fresh();
    stall = 1; call = 1; imm = 12'd3; set_z = 1; alu_z = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pc !== 16'd0 || ras_empty !== 1'b1 || z_flag !== 1'b0) begin
        bad++; $display("FAIL stall_hold: pc=%h empty=%b z=%b expected 0000 1 0", pc, ras_empty, z_flag);
      end
    end
    stall = 0;
    step();
    chk_pc("stall_call", 16'd4);
    total++;
    if (ras_empty !== 1'b0 || z_flag !== 1'b1) begin
      bad++; $display("FAIL stall_release: empty=%b z=%b expected 0 1", ras_empty, z_flag);
    end
    call = 0; set_z = 0; ret = 1;
    step();
    chk_pc("stall_ret", 16'd1);
    total++;
    if (ras_empty !== 1'b1) begin bad++; $display("FAIL stall_once: empty=%b expected 1", ras_empty); end
    ret = 0;
  endtask

  task automatic test_halt();
    fresh();
    for (int i = 0; i < 7; i++) step();
    chk_pc("reach7", 16'd7);
    hlt_in = 1; br = 1; cond = 3'b111; imm = 12'd5;
    step();
    chk_pc("halt_pc", 16'd7);
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL halt_set: halted=%b expected 1", halted); end
    hlt_in = 0; call = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (pc !== 16'd7 || halted !== 1'b1 || ras_empty !== 1'b1) begin
        bad++; $display("FAIL halt_hold: pc=%h halted=%b empty=%b expected 0007 1 1", pc, halted, ras_empty);
      end
    end
    #2 rst_n = 0;
    #1;
    total++;
    if (pc !== 16'd0 || halted !== 1'b0) begin
      bad++; $display("FAIL async_reset: pc=%h halted=%b expected 0000 0", pc, halted);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    step();
    chk_pc("post_reset_first", 16'd1);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_branch_flags();
    test_wrap();
    test_ras();
    test_priority();
    test_stall();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
